// File: rtl/soc_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_pio_pkg
// Purpose  : Shared register addresses and mode encodings for the PIO slave.
// Revision : 1.0 - initial release
// ============================================================================
package soc_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage
`default_nettype wire

// File: rtl/soc_pio_sync.sv
`default_nettype none
// ============================================================================
// Module   : soc_pio_sync
// Purpose  : Per-bit input synchroniser, history flop and raw edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module soc_pio_sync
    import soc_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
            r_prev <= '0;
        end else begin
            r_chain[0] <= pio_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
            r_prev <= r_chain[SYNC_STAGES-1];
        end
    end

    assign sync_in = r_chain[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign edge_det = sync_in & ~r_prev;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_det = ~sync_in & r_prev;
        end else begin : g_any
            assign edge_det = sync_in ^ r_prev;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/soc_pio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : soc_pio_ctrl
// Purpose  : Avalon-MM parallel I/O slave: register file, arm counter,
//            read mux and interrupt flop around the input synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module soc_pio_ctrl
    import soc_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               IRQ_MODE    = 1,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe,
    output logic             irq
);

    localparam logic [2:0] c_ARM_MAX = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_capture;
    logic [31:0]      r_readdata;
    logic [2:0]       r_arm_cnt;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_capture_next;
    logic [31:0]      w_rdata;
    logic             w_write;
    logic             w_read;
    logic             w_armed;
    logic             w_irq_next;
    logic             w_unused_wd;

    assign w_write     = chipselect & ~write_n;
    assign w_read      = chipselect & ~read_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;

    soc_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .pio_in   (pio_in),
        .sync_in  (w_sync_in),
        .edge_det (w_edge_raw)
    );

    // Edges stay masked until the synchroniser chain and history flop hold real pin data.
    assign w_armed = (r_arm_cnt == c_ARM_MAX);
    assign w_edge  = w_armed ? w_edge_raw : '0;

    always_comb begin
        w_capture_next = r_capture;
        if (w_write && address == ADDR_EDGE) w_capture_next = r_capture & ~w_wd;
        w_capture_next = w_capture_next | w_edge;
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA: w_rdata[WIDTH-1:0] = (r_out & r_dir) | (w_sync_in & ~r_dir);
            ADDR_DIR:  w_rdata[WIDTH-1:0] = r_dir;
            ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
            ADDR_EDGE: w_rdata[WIDTH-1:0] = r_capture;
            default:   w_rdata = '0;
        endcase
    end

    generate
        if (IRQ_MODE == IRQ_EDGE) begin : g_irq_edge
            assign w_irq_next = |(r_capture & r_mask);
        end else begin : g_irq_level
            assign w_irq_next = |(w_sync_in & r_mask);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out      <= OUT_RESET;
            r_dir      <= DIR_RESET;
            r_mask     <= '0;
            r_capture  <= '0;
            r_readdata <= '0;
            r_arm_cnt  <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
            r_capture <= w_capture_next;
            r_irq     <= w_irq_next;
            if (w_read) r_readdata <= w_rdata;
            if (w_write) begin
                case (address)
                    ADDR_DATA:   r_out  <= w_wd;
                    ADDR_DIR:    r_dir  <= w_wd;
                    ADDR_MASK:   r_mask <= w_wd;
                    ADDR_OUTSET: r_out  <= r_out | w_wd;
                    ADDR_OUTCLR: r_out  <= r_out & ~w_wd;
                    default:     ;
                endcase
            end
        end
    end

    assign readdata = r_readdata;
    assign pio_out  = r_out;
    assign pio_oe   = r_dir;
    assign irq      = r_irq;

endmodule
`default_nettype wire
